// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC scan controller: masked round-robin over CH channels,
// N-bit binary search per sample, 2^AVG_LOG2-sample averaging, valid/ready result register.
module sar_adc_scan #(
    parameter int N        = 10,
    parameter int CH       = 4,
    parameter int VIN_W    = 13,
    parameter int VREF     = 5000,
    parameter int AVG_LOG2 = 0,
    localparam int LSB     = VREF / (1 << N),
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  abort,
    input  logic [CH-1:0]         ch_mask,
    input  logic [CH*VIN_W-1:0]   vin,
    output logic [N-1:0]          dout,
    output logic [CHW-1:0]        dout_ch,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  overrun
);
    localparam int BW   = $clog2(N);
    localparam int CW   = AVG_LOG2 + 1;
    localparam int AW   = N + AVG_LOG2;
    localparam int CMPW = VIN_W + N;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, ACCUM} state_t;

    state_t            state_q, state_d;
    logic [VIN_W-1:0]  vin_s_q, vin_s_d;
    logic [N-1:0]      code_q, code_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CH-1:0]     mask_q, mask_d;
    logic              cont_q, cont_d;
    logic [N-1:0]      dout_q, dout_d;
    logic [CHW-1:0]    dout_ch_q, dout_ch_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    // {found, index} of the lowest set mask bit strictly above cur
    function automatic logic [CHW:0] find_above(input logic [CH-1:0] m, input logic [CHW-1:0] cur);
        logic [CHW:0] r;
        r = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) r = {1'b1, CHW'(k)};
        end
        return r;
    endfunction

    function automatic logic [CHW-1:0] lowest_set(input logic [CH-1:0] m);
        logic [CHW-1:0] r;
        r = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (m[k]) r = CHW'(k);
        end
        return r;
    endfunction

    logic            accept, comp, last_smp, aborting;
    logic [CHW:0]    nxt;
    logic [AW-1:0]   acc_sum;
    logic [CW-1:0]   cnt_inc;

    assign accept   = (state_q == IDLE) && start && (|ch_mask);
    assign aborting = abort && (state_q != IDLE);
    // Compare at full width so trial*LSB never wraps
    assign comp     = CMPW'(vin_s_q) >= (CMPW'(code_q) * CMPW'(LSB));
    assign acc_sum  = acc_q + AW'(code_q);
    assign cnt_inc  = cnt_q + 1'b1;
    assign last_smp = (cnt_inc == CW'(1 << AVG_LOG2));
    assign nxt      = find_above(mask_q, ch_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            vin_s_q   <= '0;
            code_q    <= '0;
            bit_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vin_s_q   <= vin_s_d;
            code_q    <= code_d;
            bit_q     <= bit_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            cont_q    <= cont_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SAMPLE;
            SAMPLE:  state_d = CONVERT;
            CONVERT: if (bit_q == '0) state_d = ACCUM;
            ACCUM: begin
                if (!last_smp || nxt[CHW] || cont_q) state_d = SAMPLE;
                else                                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (aborting) state_d = IDLE;
    end

    always_comb begin
        vin_s_d   = vin_s_q;
        code_d    = code_q;
        bit_d     = bit_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        cont_d    = cont_q;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        if (valid_q && dout_ready) valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mask_d = ch_mask;
                    cont_d = cont;
                    ovr_d  = 1'b0;
                    ch_d   = lowest_set(ch_mask);
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            SAMPLE: begin
                vin_s_d = vin[int'(ch_q)*VIN_W +: VIN_W];
                code_d  = N'(1) << (N - 1);
                bit_d   = BW'(N - 1);
            end
            CONVERT: begin
                if (!comp) code_d[bit_q] = 1'b0;
                if (bit_q != '0) begin
                    code_d[bit_q - 1'b1] = 1'b1;
                    bit_d = bit_q - 1'b1;
                end
            end
            ACCUM: begin
                if (!last_smp) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                end else if (!abort) begin
                    dout_d    = N'(acc_sum >> AVG_LOG2);
                    dout_ch_d = ch_q;
                    valid_d   = 1'b1;
                    if (valid_q && !dout_ready) ovr_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ch_d      = nxt[CHW] ? nxt[CHW-1:0] : lowest_set(mask_q);
                end
            end
            default: ;
        endcase
        if (aborting) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed bench for sar_adc_scan: single-channel vector table plus scan, overrun,
// abort, reset and averaging sequences.
module tb_sar_adc_scan;
    localparam int N = 10, CH = 4, VIN_W = 13, CHW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, cont, abort, dout_ready;
    logic [CH-1:0] ch_mask;
    logic [CH*VIN_W-1:0] vin;
    logic [N-1:0] dout;
    logic [CHW-1:0] dout_ch;
    logic dout_valid, busy, overrun;

    logic a_start;
    logic [CH*VIN_W-1:0] a_vin;
    logic [N-1:0] a_dout;
    logic [CHW-1:0] a_dout_ch;
    logic a_valid, a_busy, a_overrun;

    sar_adc_scan dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .abort(abort),
        .ch_mask(ch_mask), .vin(vin), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .overrun(overrun)
    );

    sar_adc_scan #(.AVG_LOG2(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .cont(1'b0), .abort(1'b0),
        .ch_mask(4'b0010), .vin(a_vin), .dout(a_dout), .dout_ch(a_dout_ch),
        .dout_valid(a_valid), .dout_ready(1'b1), .busy(a_busy), .overrun(a_overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vin(input int v0, input int v1, input int v2, input int v3);
        vin = {VIN_W'(v3), VIN_W'(v2), VIN_W'(v1), VIN_W'(v0)};
    endtask

    task automatic accept(input logic [CH-1:0] m, input logic c);
        ch_mask = m;
        cont    = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    typedef struct {
        int ch;
        int v;
        int code;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 2500, 625};
        tbl[1] = '{1, 8000, 1023};
        tbl[2] = '{2, 0, 0};
        tbl[3] = '{3, 3, 0};
        tbl[4] = '{0, 4, 1};
        tbl[5] = '{1, 4095, 1023};
        tbl[6] = '{2, 4091, 1022};
        tbl[7] = '{3, 8191, 1023};
        tbl[8] = '{0, 2047, 511};
        tbl[9] = '{1, 2048, 512};

        reset_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        ch_mask = '0; vin = '0; a_start = 1'b0; a_vin = '0;
        repeat (3) tick();
        chk("rst_dout", dout, 0);
        chk("rst_tag", dout_ch, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        tick();

        // Single-channel one-shot conversions
        for (int t = 0; t < 10; t++) begin
            set_vin(8191, 8191, 8191, 8191);
            vin[tbl[t].ch*VIN_W +: VIN_W] = VIN_W'(tbl[t].v);
            accept(CH'(1 << tbl[t].ch), 1'b0);
            repeat (11) tick();
            chk("tbl_early_valid", dout_valid, 0);
            tick();
            chk("tbl_valid", dout_valid, 1);
            chk("tbl_dout", dout, tbl[t].code);
            chk("tbl_tag", dout_ch, tbl[t].ch);
            chk("tbl_busy", busy, 0);
            tick();
            chk("tbl_drop", dout_valid, 0);
        end

        // Two-channel scan, with an ignored start mid-scan
        set_vin(2500, 8191, 0, 8191);
        accept(4'b0101, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) begin start = 1'b1; ch_mask = 4'b1000; end
            if (i == 4) start = 1'b0;
            tick();
            if (i == 11) chk("scan_early", dout_valid, 0);
            if (i == 12) begin
                chk("scan1_dout", dout, 625);
                chk("scan1_tag", dout_ch, 0);
                chk("scan1_valid", dout_valid, 1);
                chk("scan1_busy", busy, 1);
            end
            if (i == 13) chk("scan1_drop", dout_valid, 0);
            if (i == 24) begin
                chk("scan2_dout", dout, 0);
                chk("scan2_tag", dout_ch, 2);
                chk("scan2_valid", dout_valid, 1);
                chk("scan2_busy", busy, 0);
            end
        end
        tick();

        // Continuous scan with stalled consumer, then abort
        dout_ready = 1'b0;
        set_vin(100, 8191, 8191, 200);
        accept(4'b1001, 1'b1);
        for (int i = 1; i <= 37; i++) begin
            if (i == 37) abort = 1'b1;
            tick();
            abort = 1'b0;
            if (i == 12) begin
                chk("cont1_valid", dout_valid, 1);
                chk("cont1_tag", dout_ch, 0);
                chk("cont1_dout", dout, 25);
                chk("cont1_ovr", overrun, 0);
            end
            if (i == 24) begin
                chk("cont2_tag", dout_ch, 3);
                chk("cont2_dout", dout, 50);
                chk("cont2_ovr", overrun, 1);
            end
            if (i == 36) begin
                chk("cont3_tag", dout_ch, 0);
                chk("cont3_dout", dout, 25);
                chk("cont3_ovr", overrun, 1);
                chk("cont3_busy", busy, 1);
            end
            if (i == 37) begin
                chk("cabort_busy", busy, 0);
                chk("cabort_valid", dout_valid, 1);
                chk("cabort_dout", dout, 25);
                chk("cabort_ovr", overrun, 1);
            end
        end

        // Empty-mask start is ignored
        ch_mask = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("m0_busy", busy, 0);
        chk("m0_ovr", overrun, 1);
        chk("m0_valid", dout_valid, 1);
        tick();
        chk("m0_busy2", busy, 0);

        // Accepted start clears overrun
        dout_ready = 1'b1;
        set_vin(0, 0, 1234, 0);
        accept(4'b0100, 1'b0);
        chk("acc_ovr_clr", overrun, 0);
        chk("acc_busy", busy, 1);
        chk("acc_valid_drop", dout_valid, 0);
        repeat (12) tick();
        chk("ch2_dout", dout, 308);
        chk("ch2_tag", dout_ch, 2);
        chk("ch2_valid", dout_valid, 1);

        // Abort during CONVERT of channel 2
        dout_ready = 1'b0;
        set_vin(0, 0, 4000, 0);
        accept(4'b0100, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) abort = 1'b1;
            tick();
            abort = 1'b0;
            if (i == 5) chk("abort_busy", busy, 0);
            if (i == 14) begin
                chk("abort_valid", dout_valid, 1);
                chk("abort_dout", dout, 308);
                chk("abort_tag", dout_ch, 2);
                chk("abort_busy2", busy, 0);
                chk("abort_ovr", overrun, 0);
            end
        end

        // Asynchronous reset mid-CONVERT
        set_vin(2500, 0, 0, 0);
        accept(4'b0001, 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_dout", dout, 0);
        chk("mrst_tag", dout_ch, 0);
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovr", overrun, 0);
        tick();
        reset_n = 1'b1;
        dout_ready = 1'b1;
        accept(4'b0001, 1'b0);
        repeat (12) tick();
        chk("post_rst_dout", dout, 625);
        chk("post_rst_valid", dout_valid, 1);

        // Four-sample averaging; vin disturbed while converting
        a_vin[VIN_W +: VIN_W] = 13'd1000;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 1; i <= 48; i++) begin
            tick();
            case (i)
                1, 26:  a_vin[VIN_W +: VIN_W] = 13'd8191;
                12, 36: a_vin[VIN_W +: VIN_W] = 13'd1003;
                14, 38: a_vin[VIN_W +: VIN_W] = 13'd0;
                24:     a_vin[VIN_W +: VIN_W] = 13'd1000;
                default: ;
            endcase
            if (i == 47) begin
                chk("avg_early", a_valid, 0);
                chk("avg_busy", a_busy, 1);
            end
            if (i == 48) begin
                chk("avg_dout", a_dout, 250);
                chk("avg_valid", a_valid, 1);
                chk("avg_tag", a_dout_ch, 1);
                chk("avg_busy_end", a_busy, 0);
                chk("avg_ovr", a_overrun, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sar_adc_scan.md
Name: sar_adc_scan

Overview:
- Multi-channel successor to the single-channel SAR ADC controller.
- Scans up to CH analog channels (digital mV models) in a masked round-robin sequence, in one-shot or continuous mode.
- Runs an N-bit binary search per sample and averages 2^AVG_LOG2 samples per channel.
- Each result goes out through a single-entry valid/ready result register with channel tag and sticky overrun flag; it sits between the analog front-end model and the sensor-readout logic.

Parameters:
- N, 10, resolution in bits (2..16).
- CH, 4, number of input channels (1..16).
- VIN_W, 13, width of each channel's mV input.
- VREF, 5000, reference voltage in mV.
- LSB, VREF/(1<<N), integer mV per code step (floor; 4 at defaults).
- AVG_LOG2, 0, log2 of samples averaged per channel (0..4).
- CHW, max(1,$clog2(CH)), channel tag width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin scan when idle (single-cycle pulse or level).
- cont  in  1  continuous mode, latched at accepted start.
- abort  in  1  synchronous abort of scan in progress.
- ch_mask  in  CH  enabled channels, latched at accepted start.
- vin  in  CH*VIN_W  channel k at bits [k*VIN_W +: VIN_W], unsigned mV.
- dout  out  N  averaged result code.
- dout_ch  out  CHW  channel index of dout.
- dout_valid  out  1  result available.
- dout_ready  in  1  consumer accepts result.
- busy  out  1  high from accepted start until return to IDLE.
- overrun  out  1  sticky: unconsumed result was overwritten.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; internal accumulator, sample count, channel pointer and latched mask/cont cleared.
- States: IDLE, SAMPLE, CONVERT, ACCUM.
- IDLE:
  - start=1 with ch_mask!=0 is accepted: latch ch_mask and cont, clear overrun, select lowest set channel, busy=1, go to SAMPLE.
  - start with ch_mask==0 is ignored.
  - start while busy is ignored.
- SAMPLE (1 cycle): capture current channel's vin into vin_s; trial code = 1<<(N-1); bit index = N-1; go to CONVERT.
- CONVERT (N cycles, MSB first):
  - comp = (vin_s >= trial*LSB), evaluated at VIN_W+N bits with no truncation.
  - If !comp, clear the current bit. If the bit index is not 0, set the next lower bit and decrement the index.
  - After bit 0, go to ACCUM.
  - Final code is the largest c with c*LSB <= vin_s, saturating at 2^N-1.
- ACCUM (1 cycle): acc += code (acc width N+AVG_LOG2); increment sample count.
  - Fewer than 2^AVG_LOG2 samples taken: back to SAMPLE on the same channel.
  - Otherwise publish: dout <= acc>>AVG_LOG2 (truncating), dout_ch <= channel, dout_valid <= 1; clear acc and count; advance to the next set mask bit above the current channel.
  - Past the highest set bit: with cont=1, wrap to the lowest set bit and go to SAMPLE; with cont=0, go to IDLE with busy<=0 on the same edge.
- Per-channel latency: (N+2)*2^AVG_LOG2 cycles; dout_valid rises on the edge ending the last ACCUM.
- Handshake:
  - dout_valid stays high until a clock edge sees dout_ready=1 with no publish on that edge; then it drops.
  - Publish while dout_valid=1 and dout_ready=0: new data overwrites, overrun<=1 (sticky until next accepted start).
  - Publish on the same edge as dout_ready=1: new data loads, dout_valid stays 1, no overrun.
- Abort: at any non-IDLE state go to IDLE next edge with busy<=0; discard partial acc and count. dout, dout_ch, dout_valid and overrun are unaffected. Abort has priority over publish on the same edge.
- vin changes after SAMPLE do not affect the ongoing conversion.

Test Plan:
- Reset mid-CONVERT (reset_n low 1 cycle) -> all outputs 0 immediately, state IDLE, a subsequent start works normally.
- Defaults, ch_mask=4'b0101, cont=0, vin ch0=2500, ch2=0, dout_ready=1 -> dout=625 tag 0 at cycle 12 after start acceptance, then dout=0 tag 2 at cycle 24, busy falls with second publish; vin=8000 on a channel -> 1023.
- AVG_LOG2=2, ch1 vin alternating 1000/1003 per SAMPLE -> codes 250/250/250/250, dout=250, latency 48 cycles.
- cont=1, ch_mask=4'b1001, dout_ready=0 -> first publish tag 0 valid, second (tag 3) sets overrun=1, third is tag 0 again (wrap); overrun clears only on the next accepted start.
- abort asserted during CONVERT of channel 2 -> IDLE next cycle, busy=0, previous dout/dout_valid retained, no new publish.
- start with ch_mask=0, and start while busy -> ignored: busy, dout_valid and state unchanged.
